// File: rtl/linalg_pkg.sv
// Shared fixed-point linear-algebra types and helpers for the 4x4 transform blocks.
package linalg_pkg;

  localparam int FXP_WI   = 9;
  localparam int FXP_WF   = 16;
  localparam int FXP_W    = FXP_WI + FXP_WF;
  localparam int FXP_ACCW = 2*FXP_W + 2;

  typedef logic signed [FXP_W-1:0]    fxp_t;
  typedef logic signed [FXP_ACCW-1:0] acc_t;
  typedef logic [3:0][FXP_W-1:0]      vec4_t;
  typedef logic [3:0][3:0][FXP_W-1:0] mat4_t;

  localparam fxp_t FXP_ONE = fxp_t'(1 << FXP_WF);
  localparam acc_t FXP_MAX = acc_t'((1 << (FXP_W-1)) - 1);
  localparam acc_t FXP_MIN = acc_t'(-(1 << (FXP_W-1)));

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_DONE} inv_state_t;

  typedef struct packed {
    logic clip;
    fxp_t val;
  } sat_res_t;

  // Negate the full-precision sum, drop the product's extra fraction bits
  // (floor), then clip to the element range.
  function automatic sat_res_t fxp_sat_shift(input acc_t acc);
    acc_t     shr;
    sat_res_t res;
    shr = (-acc) >>> FXP_WF;
    res.clip = 1'b0;
    if (shr > FXP_MAX) begin
      res.val  = FXP_MAX[FXP_W-1:0];
      res.clip = 1'b1;
    end else if (shr < FXP_MIN) begin
      res.val  = FXP_MIN[FXP_W-1:0];
      res.clip = 1'b1;
    end else begin
      res.val = shr[FXP_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/homog_inverse_seq_if.sv
// Handshake bundle for the homogeneous-transform inverter.
interface homog_inverse_seq_if #(
  parameter int WI = 9,
  parameter int WF = 16
);
  logic                          in_valid;
  logic                          in_ready;
  logic [3:0][3:0][WI+WF-1:0]    H_in;
  logic                          out_valid;
  logic                          out_ready;
  logic [3:0][3:0][WI+WF-1:0]    Hinv_out;
  logic                          sat;
  logic                          bad_row;

  modport master (
    output in_valid, H_in, out_ready,
    input  in_ready, out_valid, Hinv_out, sat, bad_row
  );

  modport slave (
    input  in_valid, H_in, out_ready,
    output in_ready, out_valid, Hinv_out, sat, bad_row
  );
endinterface

// File: rtl/fxp_mac.sv
// Signed multiply-accumulate: sum = (clr ? 0 : acc) + a*b, registered when en.
module fxp_mac #(
  parameter int AW   = 25,
  parameter int BW   = 25,
  parameter int ACCW = 52
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [AW-1:0]   a,
  input  logic signed [BW-1:0]   b,
  output logic signed [ACCW-1:0] sum
);
  logic signed [AW+BW-1:0] prod_p0;
  logic signed [ACCW-1:0]  acc_p1;

  // Full-precision product and the value the accumulator will take
  always_comb begin
    prod_p0 = a * b;
    sum     = (clr ? '0 : acc_p1) + $signed({{(ACCW-AW-BW){prod_p0[AW+BW-1]}}, prod_p0});
  end

  // Accumulator register; data only, cleared through clr rather than reset
  always_ff @(posedge clk) begin
    if (en) acc_p1 <= sum;
  end
endmodule

// File: rtl/homog_inverse_seq.sv
// Sequential inverse of a rigid 4x4 homogeneous transform: R^T and -R^T t,
// with the translation computed on one shared MAC over nine cycles.
module homog_inverse_seq
  import linalg_pkg::*;
#(
  parameter int WI   = FXP_WI,
  parameter int WF   = FXP_WF,
  parameter int ACCW = 2*(WI+WF)+2
) (
  input logic          clk,
  input logic          reset,
  homog_inverse_seq_if.slave bus
);
  localparam int W = WI + WF;
  localparam logic [W-1:0] ONE_W = W'(1) << WF;

  inv_state_t state_q, state_d;
  logic [1:0] r_q, r_d, k_q, k_d;
  logic [3:0][3:0][W-1:0] h_q;
  logic [3:0][3:0][W-1:0] hinv_q;
  logic sat_q, bad_q;
  logic mac_en, mac_clr, accept;
  logic signed [W-1:0]    mac_a, mac_b;
  logic signed [ACCW-1:0] mac_sum;
  sat_res_t t_res;

  assign accept = (state_q == ST_IDLE) && bus.in_valid;
  assign t_res  = fxp_sat_shift(mac_sum);

  fxp_mac #(.AW(W), .BW(W), .ACCW(ACCW)) u_mac (
    .clk (clk),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (mac_a),
    .b   (mac_b),
    .sum (mac_sum)
  );

  // Control state: FSM plus row/column counters of the dot products
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      r_q     <= 2'd0;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      k_q     <= k_d;
    end
  end

  // Next state and MAC sequencing: t'_r = -sum_k H[r][k] * H[3][k]
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    k_d     = k_q;
    mac_en  = 1'b0;
    mac_clr = 1'b0;
    mac_a   = h_q[r_q][k_q];
    mac_b   = h_q[3][k_q];
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_MAC;
          r_d     = 2'd0;
          k_d     = 2'd0;
        end
      end
      ST_MAC: begin
        mac_en  = 1'b1;
        mac_clr = (k_q == 2'd0);
        if (k_q == 2'd2) begin
          k_d = 2'd0;
          if (r_q == 2'd2) state_d = ST_DONE;
          else             r_d     = r_q + 2'd1;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture; held untouched until the next accept
  always_ff @(posedge clk) begin
    if (accept) h_q <= bus.H_in;
  end

  // Result matrix and flags: fixed fields at capture, translation per row
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hinv_q <= '0;
      sat_q  <= 1'b0;
      bad_q  <= 1'b0;
    end else if (accept) begin
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          if (c < 3 && r < 3)       hinv_q[c][r] <= bus.H_in[r][c];
          else if (c == 3 && r == 3) hinv_q[c][r] <= ONE_W;
          else                      hinv_q[c][r] <= '0;
        end
      end
      sat_q <= 1'b0;
      bad_q <= (bus.H_in[0][3] != '0) | (bus.H_in[1][3] != '0) |
               (bus.H_in[2][3] != '0) | (bus.H_in[3][3] != ONE_W);
    end else if (state_q == ST_MAC && k_q == 2'd2) begin
      hinv_q[3][r_q] <= t_res.val;
      if (t_res.clip) sat_q <= 1'b1;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.Hinv_out  = hinv_q;
  assign bus.sat       = sat_q;
  assign bus.bad_row   = bad_q;
endmodule

// File: tb/tb_homog_inverse_seq.sv
// Bench for homog_inverse_seq: directed table, multi-cycle corner sequences,
// and random transforms against an arithmetic reference.
module tb_homog_inverse_seq;
  localparam int W = 25;
  localparam logic [W-1:0] ONE = 25'h0010000;

  typedef logic [3:0][3:0][W-1:0] mat_t;
  typedef struct {
    mat_t h;
    mat_t exp_inv;
    logic exp_sat;
    logic exp_bad;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_bad = 0;

  homog_inverse_seq_if #(.WI(9), .WF(16)) bus();

  homog_inverse_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic mat_t ident();
    mat_t m = '0;
    for (int i = 0; i < 4; i++) m[i][i] = ONE;
    return m;
  endfunction

  // Reference: Hinv = [R^T, -R^T t], t' floored to the fraction grid and clipped.
  function automatic void model(input mat_t h, output mat_t inv, output logic s, output logic b);
    longint acc;
    longint v;
    inv = '0;
    s   = 1'b0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        inv[c][r] = h[r][c];
    inv[3][3] = ONE;
    for (int r = 0; r < 3; r++) begin
      acc = 0;
      for (int k = 0; k < 3; k++)
        acc += longint'($signed(h[r][k])) * longint'($signed(h[3][k]));
      v = (-acc) >>> 16;
      if (v > 64'sd16777215) begin
        v = 64'sd16777215;
        s = 1'b1;
      end else if (v < -64'sd16777216) begin
        v = -64'sd16777216;
        s = 1'b1;
      end
      inv[3][r] = v[W-1:0];
    end
    b = (h[0][3] != '0) || (h[1][3] != '0) || (h[2][3] != '0) || (h[3][3] != ONE);
  endfunction

  // Present h, accept it, then wait (bounded) until out_valid is seen high.
  // lat counts edges from the accept edge to the first edge sampling out_valid=1.
  task automatic start_and_wait(input mat_t h, output int lat, output bit ok);
    int guard;
    ok    = 1'b1;
    guard = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) ok = 1'b0;
    bus.H_in     = h;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (bus.out_valid !== 1'b1) ok = 1'b0;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input mat_t h, input mat_t ei, input logic es, input logic eb, input string tag);
    int lat;
    bit ok;
    start_and_wait(h, lat, ok);
    check({tag, " out_valid seen"}, 512'(ok), 512'(1));
    check({tag, " latency"}, 512'(lat), 512'(10));
    check({tag, " Hinv"}, 512'(bus.Hinv_out), 512'(ei));
    check({tag, " sat"}, 512'(bus.sat), 512'(es));
    check({tag, " bad_row"}, 512'(bus.bad_row), 512'(eb));
    handshake();
    check({tag, " in_ready after handshake"}, 512'(bus.in_ready), 512'(1));
    check({tag, " out_valid after handshake"}, 512'(bus.out_valid), 512'(0));
  endtask

  initial begin
    vec_t tbl[4];
    mat_t h, ei, snap;
    logic es, eb, snap_sat, snap_bad;
    int lat;
    bit ok, stable, irdy_low;
    int v;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.H_in      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 512'(bus.in_ready), 512'(1));
    check("reset out_valid", 512'(bus.out_valid), 512'(0));
    check("reset sat", 512'(bus.sat), 512'(0));
    check("reset bad_row", 512'(bus.bad_row), 512'(0));
    check("reset Hinv", 512'(bus.Hinv_out), 512'(0));
    @(negedge clk) reset = 1'b0;

    // Directed table
    tbl[0].h = ident();
    tbl[0].h[3][0] = 25'h0010000;
    tbl[0].h[3][1] = 25'h0020000;
    tbl[0].h[3][2] = 25'h0030000;
    tbl[0].exp_inv = ident();
    tbl[0].exp_inv[3][0] = 25'h1FF0000;
    tbl[0].exp_inv[3][1] = 25'h1FE0000;
    tbl[0].exp_inv[3][2] = 25'h1FD0000;
    tbl[0].exp_sat = 1'b0;
    tbl[0].exp_bad = 1'b0;

    tbl[1].h = ident();
    tbl[1].h[0][0] = '0;
    tbl[1].h[1][1] = '0;
    tbl[1].h[1][0] = 25'h1FF0000;
    tbl[1].h[0][1] = ONE;
    tbl[1].h[3][0] = ONE;
    tbl[1].exp_inv = ident();
    tbl[1].exp_inv[0][0] = '0;
    tbl[1].exp_inv[1][1] = '0;
    tbl[1].exp_inv[0][1] = 25'h1FF0000;
    tbl[1].exp_inv[1][0] = ONE;
    tbl[1].exp_inv[3][1] = ONE;
    tbl[1].exp_sat = 1'b0;
    tbl[1].exp_bad = 1'b0;

    tbl[2].h = '0;
    tbl[2].exp_inv = '0;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 3; r++) begin
        tbl[2].h[c][r]       = ONE;
        tbl[2].exp_inv[c][r] = ONE;
      end
      tbl[2].h[3][c]       = 25'h0C80000;
      tbl[2].exp_inv[3][c] = 25'h1000000;
    end
    tbl[2].h[3][3]       = ONE;
    tbl[2].exp_inv[3][3] = ONE;
    tbl[2].exp_sat = 1'b1;
    tbl[2].exp_bad = 1'b0;

    tbl[3].h = tbl[0].h;
    tbl[3].h[2][3] = ONE;
    tbl[3].exp_inv = tbl[0].exp_inv;
    tbl[3].exp_sat = 1'b0;
    tbl[3].exp_bad = 1'b1;

    for (int i = 0; i < 4; i++)
      run_vec(tbl[i].h, tbl[i].exp_inv, tbl[i].exp_sat, tbl[i].exp_bad, $sformatf("vec%0d", i));

    // Backpressure: result and flags held, no second accept while DONE
    start_and_wait(tbl[2].h, lat, ok);
    check("bp out_valid seen", 512'(ok), 512'(1));
    check("bp Hinv", 512'(bus.Hinv_out), 512'(tbl[2].exp_inv));
    snap     = bus.Hinv_out;
    snap_sat = bus.sat;
    snap_bad = bus.bad_row;
    stable   = 1'b1;
    irdy_low = 1'b1;
    bus.H_in     = ident();
    bus.in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.Hinv_out !== snap || bus.sat !== snap_sat || bus.bad_row !== snap_bad ||
          bus.out_valid !== 1'b1)
        stable = 1'b0;
      if (bus.in_ready !== 1'b0) irdy_low = 1'b0;
    end
    bus.in_valid = 1'b0;
    check("bp outputs stable", 512'(stable), 512'(1));
    check("bp in_ready low", 512'(irdy_low), 512'(1));
    check("bp sat held", 512'(bus.sat), 512'(1));
    handshake();
    check("bp out_valid dropped", 512'(bus.out_valid), 512'(0));
    check("bp in_ready back", 512'(bus.in_ready), 512'(1));
    repeat (12) @(posedge clk);
    #1 check("bp no second result", 512'(bus.out_valid), 512'(0));

    // Reset in the middle of the MAC phase
    @(negedge clk);
    bus.H_in     = tbl[2].h;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset out_valid", 512'(bus.out_valid), 512'(0));
    check("midreset in_ready", 512'(bus.in_ready), 512'(1));
    check("midreset Hinv", 512'(bus.Hinv_out), 512'(0));
    check("midreset sat", 512'(bus.sat), 512'(0));
    @(negedge clk) reset = 1'b0;
    run_vec(tbl[0].h, tbl[0].exp_inv, 1'b0, 1'b0, "after reset");

    // Random transforms against the reference
    for (int it = 0; it < 24; it++) begin
      h = ident();
      for (int c = 0; c < 3; c++) begin
        for (int r = 0; r < 3; r++) begin
          v = int'($urandom_range(0, 262143)) - 131072;
          h[c][r] = v[W-1:0];
        end
        if (it % 3 == 0) begin
          v = int'($urandom());
        end else begin
          v = int'($urandom_range(0, 8388607)) - 4194304;
        end
        h[3][c] = v[W-1:0];
      end
      if (it % 5 == 4) begin
        v = int'($urandom());
        h[1][3] = v[W-1:0];
      end
      model(h, ei, es, eb);
      run_vec(h, ei, es, eb, $sformatf("rand%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/homog_inverse_seq.md
Name: homog_inverse_seq

Overview:
Sequential inverter for 4x4 rigid homogeneous transforms in signed fixed point. Takes H = [R t; 0 0 0 1] and returns H^-1 = [R^T, -R^T t; 0 0 0 1].
- Provides the inverse direction of the 4x4-on-4x1 matrix multiplier: frame-to-world results map back into the local frame.
- Uses one shared multiply-accumulate unit over 9 cycles, with valid/ready handshakes on input and output.

Parameters:
WI, 9, integer bits of every element, sign included
WF, 16, fraction bits of every element
ACCW, 2*(WI+WF)+2, accumulator width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  H_in is valid
in_ready  out  1  block can accept H_in
H_in  in  [3:0][3:0][WI+WF-1:0]  input matrix, signed; H_in[c][r] = row r, column c
out_valid  out  1  Hinv_out is valid
out_ready  in  1  consumer accepts Hinv_out
Hinv_out  out  [3:0][3:0][WI+WF-1:0]  inverse matrix, same indexing
sat  out  1  at least one translation term of the current result saturated
bad_row  out  1  H_in bottom row was not [0 0 0 1.0]

Behaviour:
- Reset (async, active-high):
  - state=IDLE; in_ready=1; out_valid=0; sat=0; bad_row=0; Hinv_out=0.
  - Asserting reset mid-computation aborts the operation and discards all partial state.
- States: IDLE, MAC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge t: capture H_in into an internal register; compute bad_row = (H[0][3]!=0 | H[1][3]!=0 | H[2][3]!=0 | H[3][3]!=1<<WF); clear sat; go to MAC with r=0, k=0.
- MAC (cycles t+1..t+9):
  - in_ready=0.
  - Each cycle: acc += H[r][k] * H[3][k], with full-precision signed product. acc clears on k=0.
  - On k=2: t'_r = sat(-(acc) >>> WF), i.e. negate, then arithmetic shift right by WF, then saturate to [-2^(WI+WF-1), 2^(WI+WF-1)-1]. Write t'_r into Hinv[3][r]; set sat if clipping occurred.
  - k wraps 2->0 and r increments. After r=2,k=2, go to DONE.
- Fixed output fields, written at capture or before DONE:
  - Hinv[c][r] = H[r][c] for r,c in 0..2 (transpose).
  - Hinv[0..2][3] = 0; Hinv[3][3] = 1<<WF.
- DONE:
  - out_valid=1 starting at edge t+10.
  - Hinv_out, sat and bad_row are held stable until out_valid&out_ready.
  - On that handshake: out_valid=0 and return to IDLE at the next edge.
  - in_valid is ignored while not in IDLE (in_ready=0).
- Latency and throughput:
  - Input accept to out_valid is 10 cycles.
  - Minimum initiation interval is 11 cycles (out_ready held high).
- bad_row does not alter computation; the inverse is still produced as if the bottom row were [0 0 0 1].
- Orthonormality of R is not checked; the block always computes R^T and -R^T t literally.

Decomposition:
- Shared package linalg_pkg:
  - fixed-point typedefs fxp_t (signed WI+WF) and mat4_t / vec4_t packed arrays
  - constant FXP_ONE = 1<<WF
  - function fxp_sat_shift(acc) for the shift-and-saturate rule
  - shared by the 4x4-on-4x1 multiplier and this block.
- One sub-module: fxp_mac: signed multiplier plus accumulator with a clr/en interface. It is reused later for a sequential matrix multiply.

Test Plan:
- Identity R, t=(1.0,2.0,3.0) (H[3][0..2]=0x10000,0x20000,0x30000) -> Hinv translation = (-1.0,-2.0,-3.0) = 0x1FF0000, 0x1FE0000, 0x1FD0000 (25-bit); R part is identity; sat=0, bad_row=0; out_valid exactly 10 cycles after accept.
- 90 deg z rotation (H[1][0]=-1.0, H[0][1]=1.0, H[2][2]=1.0), t=(1.0,0,0) -> Hinv[0][1]=-1.0, Hinv[1][0]=1.0; translation (0, 1.0, 0).
- R all 1.0, t=(200.0,200.0,200.0) -> each raw term is -600.0, so every t'_r = -256.0 (0x1000000); sat=1.
- Backpressure: hold out_ready=0 for 20 cycles -> Hinv_out and flags stable, in_ready=0 throughout, second in_valid not accepted; release -> one handshake, then in_ready=1 on the next cycle.
- Bottom row [0 0 1.0 1.0] -> bad_row=1; inverse computed as if the row were [0 0 0 1].
- Assert reset at cycle t+5 -> out_valid=0, in_ready=1 immediately; a fresh identity input afterwards yields a correct result 10 cycles after accept.
